// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes used by the main decoder and the multiply
// sequencer, plus the sequencer state encoding.
package alu_pkg;

    localparam int unsigned ALU_W = 32;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_LUI = 4'b0001;
    localparam logic [3:0] ALUC_SUB = 4'b0010;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_AND = 4'b0100;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0110;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_SHL  = 3'd2,
        S_SHR  = 3'd3,
        S_DONE = 3'd4
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiply sequencer that borrows the shared single-cycle ALU from
// the datapath; transparent pass-through whenever it is idle.
import alu_pkg::*;

module alu_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] mul_a,
    input  logic [31:0] mul_b,
    input  logic [31:0] dp_a,
    input  logic [31:0] dp_b,
    input  logic [3:0]  dp_aluc,
    output logic [31:0] dp_r,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_r,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    // Handshake: start is accepted only on a rising edge where busy is low;
    // busy stays high from the next cycle through the done pulse, and result
    // holds the product from the cycle after done until the next done.
    mul_state_t  state;
    mul_state_t  state_n;
    logic [31:0] m_reg;
    logic [31:0] q_reg;
    logic [31:0] p_reg;

    always_comb begin
        state_n  = state;
        alu_a    = dp_a;
        alu_b    = dp_b;
        alu_aluc = dp_aluc;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (mul_b == 32'd0)
                        state_n = S_DONE;
                    else if (mul_b[0])
                        state_n = S_ADD;
                    else
                        state_n = S_SHL;
                end
            end
            S_ADD: begin
                alu_a    = p_reg;
                alu_b    = m_reg;
                alu_aluc = ALUC_ADD;
                state_n  = S_SHL;
            end
            S_SHL: begin
                alu_a    = 32'd1;
                alu_b    = m_reg;
                alu_aluc = ALUC_SLL;
                state_n  = S_SHR;
            end
            S_SHR: begin
                alu_a    = 32'd1;
                alu_b    = q_reg;
                alu_aluc = ALUC_SRL;
                // Decide on the freshly shifted multiplier, not the stale Q.
                if (alu_r == 32'd0)
                    state_n = S_DONE;
                else if (alu_r[0])
                    state_n = S_ADD;
                else
                    state_n = S_SHL;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            m_reg  <= 32'd0;
            q_reg  <= 32'd0;
            p_reg  <= 32'd0;
            result <= 32'd0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_reg <= mul_a;
                        q_reg <= mul_b;
                        p_reg <= 32'd0;
                    end
                end
                S_ADD:   p_reg  <= alu_r;
                S_SHL:   m_reg  <= alu_r;
                S_SHR:   q_reg  <= alu_r;
                S_DONE:  result <= p_reg;
                default: ;
            endcase
        end
    end

    assign dp_r = alu_r;
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
